axil_rr_arbiter: RTL and testbench

Two-master AXI4-Lite arbiter and address decoder in front of the SRAM/UART slave crossbar. Master 0 (instruction fetch) is read-only; master 1 (load/store unit) issues reads and writes. The block grants one outstanding transaction at a time using round-robin between masters. It drives a single downstream slave port plus a registered slave-select, and answers out-of-window addresses itself with an error response.

---
 rtl/axil_rr_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_axil_rr_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_rr_arbiter.sv
// Two-master AXI4-Lite arbiter and address decoder. One transaction is in flight at a time.
// Out-of-window addresses are answered locally with an error response.
module axil_rr_arbiter #(
    parameter logic [31:0] SRAM_BASE = 32'h8000_0000,
    parameter logic [31:0] SRAM_MASK = 32'hFF00_0000,
    parameter logic [31:0] UART_BASE = 32'h1000_0000,
    parameter logic [31:0] UART_MASK = 32'hFFFF_F000,
    parameter int          STRB_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    // master 0: instruction fetch, read only
    input  logic [31:0]       m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [31:0]       m0_rdata,
    output logic              m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    // master 1: load/store unit
    input  logic [31:0]       m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [31:0]       m1_rdata,
    output logic              m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    input  logic [31:0]       m1_awaddr,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [31:0]       m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    output logic              m1_bresp,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    // downstream slave port
    output logic [31:0]       s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [31:0]       s_rdata,
    input  logic              s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [31:0]       s_awaddr,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [31:0]       s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    output logic              s_wvalid,
    input  logic              s_wready,
    input  logic              s_bresp,
    input  logic              s_bvalid,
    output logic              s_bready,
    output logic              s_sel,
    output logic              s_busy
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, ERR_R, ERR_W} state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;
    logic   sel, sel_nxt;
    logic   last_grant, last_grant_nxt;
    logic   aw_done, aw_done_nxt;
    logic   w_done, w_done_nxt;

    logic        m0_req, m1_req, grant, win_write, hit_sram, hit_uart, owner_rready;
    logic [31:0] win_addr;

    always_comb begin
        m0_req = m0_arvalid;
        m1_req = m1_arvalid | m1_awvalid;
        // A tie goes to whoever was not granted last; otherwise the sole requester wins.
        grant = (m0_req && m1_req) ? ~last_grant : m1_req;
        // Within master 1 a pending read takes precedence over a write.
        win_write = grant & ~m1_arvalid;
        win_addr  = !grant ? m0_araddr : (m1_arvalid ? m1_araddr : m1_awaddr);
        hit_sram  = (win_addr & SRAM_MASK) == SRAM_BASE;
        hit_uart  = (win_addr & UART_MASK) == UART_BASE;
        owner_rready = owner ? m1_rready : m0_rready;
    end

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        sel_nxt        = sel;
        last_grant_nxt = last_grant;
        aw_done_nxt    = aw_done;
        w_done_nxt     = w_done;
        case (state)
            IDLE: begin
                aw_done_nxt = 1'b0;
                w_done_nxt  = 1'b0;
                if (m0_req || m1_req) begin
                    owner_nxt      = grant;
                    last_grant_nxt = grant;
                    if (hit_sram || hit_uart) begin
                        sel_nxt   = ~hit_sram;
                        state_nxt = win_write ? WRITE : READ;
                    end else begin
                        state_nxt = win_write ? ERR_W : ERR_R;
                    end
                end
            end
            READ:  if (s_rvalid && s_rready) state_nxt = IDLE;
            WRITE: if (s_bvalid && s_bready) state_nxt = IDLE;
            ERR_R: begin
                // aw_done marks the one-cycle address acceptance pulse as spent.
                if (!aw_done) begin
                    aw_done_nxt = 1'b1;
                end else if (owner_rready) begin
                    aw_done_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            ERR_W: begin
                if (m1_awvalid && !aw_done) aw_done_nxt = 1'b1;
                if (m1_wvalid && !w_done)   w_done_nxt  = 1'b1;
                if (aw_done && w_done && m1_bready) begin
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m0_arready = 1'b0;  m0_rdata = '0;  m0_rresp = 1'b0;  m0_rvalid = 1'b0;
        m1_arready = 1'b0;  m1_rdata = '0;  m1_rresp = 1'b0;  m1_rvalid = 1'b0;
        m1_awready = 1'b0;  m1_wready = 1'b0;  m1_bresp = 1'b0;  m1_bvalid = 1'b0;
        s_araddr  = '0;  s_arvalid = 1'b0;  s_rready = 1'b0;
        s_awaddr  = '0;  s_awvalid = 1'b0;
        s_wdata   = '0;  s_wstrb   = '0;    s_wvalid = 1'b0;  s_bready = 1'b0;
        case (state)
            READ: begin
                s_araddr  = owner ? m1_araddr  : m0_araddr;
                s_arvalid = owner ? m1_arvalid : m0_arvalid;
                s_rready  = owner_rready;
                if (owner) begin
                    m1_arready = s_arready;
                    m1_rdata   = s_rdata;
                    m1_rresp   = s_rresp;
                    m1_rvalid  = s_rvalid;
                end else begin
                    m0_arready = s_arready;
                    m0_rdata   = s_rdata;
                    m0_rresp   = s_rresp;
                    m0_rvalid  = s_rvalid;
                end
            end
            WRITE: begin
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wvalid   = m1_wvalid;
                s_bready   = m1_bready;
                m1_awready = s_awready;
                m1_wready  = s_wready;
                m1_bresp   = s_bresp;
                m1_bvalid  = s_bvalid;
            end
            ERR_R: begin
                if (owner) begin
                    m1_arready = ~aw_done;
                    m1_rvalid  = aw_done;
                    m1_rresp   = aw_done;
                end else begin
                    m0_arready = ~aw_done;
                    m0_rvalid  = aw_done;
                    m0_rresp   = aw_done;
                end
            end
            ERR_W: begin
                m1_awready = ~aw_done;
                m1_wready  = ~w_done;
                m1_bvalid  = aw_done & w_done;
                m1_bresp   = aw_done & w_done;
            end
            default: ;
        endcase
    end

    assign s_sel  = sel;
    assign s_busy = (state == READ) || (state == WRITE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            sel        <= sel_nxt;
            last_grant <= last_grant_nxt;
            aw_done    <= aw_done_nxt;
            w_done     <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Self-checking bench for axil_rr_arbiter: decode vector table, scoreboard of responses,
// plus hand-written sequences for round-robin, stalled write response, late W and reset.
module tb_axil_rr_arbiter;

    localparam int STRB_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] m0_araddr, m0_rdata, m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
    logic m0_arvalid, m0_arready, m0_rresp, m0_rvalid, m0_rready;
    logic m1_arvalid, m1_arready, m1_rresp, m1_rvalid, m1_rready;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bresp, m1_bvalid, m1_bready;
    logic [STRB_W-1:0] m1_wstrb, s_wstrb;
    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic s_arvalid, s_arready, s_rresp, s_rvalid, s_rready;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bresp, s_bvalid, s_bready;
    logic s_sel, s_busy;

    always #5 clk = ~clk;

    axil_rr_arbiter #(.STRB_W(STRB_W)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_sel(s_sel), .s_busy(s_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [31:0] data; logic resp; } rsp_t;
    rsp_t sb0[$];
    rsp_t sb1[$];

    typedef struct { bit wr; bit mst; logic [31:0] addr; bit err; logic sel; } vec_t;
    vec_t vecs[10];

    int          rd_lat = 3;
    logic [31:0] cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: expected event did not occur within its cycle budget", name);
    endtask

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return (a == 32'h8000_0010) ? 32'hDEAD_BEEF : ~a;
    endfunction

    function automatic logic m0_any();
        return |{m0_arready, m0_rdata, m0_rresp, m0_rvalid};
    endfunction

    function automatic logic m1_any();
        return |{m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_awready, m1_wready, m1_bresp, m1_bvalid};
    endfunction

    function automatic logic any_out();
        return m0_any() | m1_any() | (|{s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid,
                                        s_wdata, s_wstrb, s_wvalid, s_bready, s_sel, s_busy});
    endfunction

    task automatic sb_push(input bit m, input rsp_t r);
        if (m) sb1.push_back(r);
        else   sb0.push_back(r);
    endtask

    task automatic sb_pop_check(input bit m, input bit is_wr, input logic [31:0] data,
                                input logic resp, input string tag);
        rsp_t e;
        if (m && sb1.size() == 0 || !m && sb0.size() == 0) begin
            fail({tag, "_sb_underflow"});
            return;
        end
        if (m) e = sb1.pop_front();
        else   e = sb0.pop_front();
        if (!is_wr) check({tag, "_rdata"}, data, e.data);
        check({tag, "_resp"}, 32'(resp), 32'(e.resp));
    endtask

    // Downstream slave model: samples handshakes on the falling edge, updates 2ns after rising.
    initial begin : slave
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, rs, rpend, awgot, wgot;
        logic [31:0] araddr_q;
        int cnt;
        s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 1'b0;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bresp = 1'b0;
        rpend = 0; awgot = 0; wgot = 0; cnt = 0; araddr_q = '0;
        forever begin
            @(negedge clk);
            rs    = rst;
            ar_hs = s_arvalid && s_arready;
            r_hs  = s_rvalid && s_rready;
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            b_hs  = s_bvalid && s_bready;
            if (ar_hs) araddr_q = s_araddr;
            if (aw_hs) cap_awaddr = s_awaddr;
            if (w_hs) begin cap_wdata = s_wdata; cap_wstrb = s_wstrb; end
            @(posedge clk);
            #2;
            if (rs) begin
                s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0;
                s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0;
                rpend = 0; awgot = 0; wgot = 0;
            end else begin
                if (ar_hs) begin
                    s_arready = 1'b0; rpend = 1; cnt = rd_lat;
                end else if (rpend && !s_rvalid) begin
                    if (cnt <= 1) begin s_rvalid = 1'b1; s_rdata = slv_data(araddr_q); end
                    else cnt--;
                end
                if (r_hs) begin s_rvalid = 1'b0; s_rdata = '0; rpend = 0; s_arready = 1'b1; end
                if (aw_hs) begin s_awready = 1'b0; awgot = 1; end
                if (w_hs)  begin s_wready = 1'b0; wgot = 1; end
                if (awgot && wgot && !s_bvalid && !b_hs) s_bvalid = 1'b1;
                if (b_hs) begin
                    s_bvalid = 1'b0; awgot = 0; wgot = 0; s_awready = 1'b1; s_wready = 1'b1;
                end
            end
        end
    end

    task automatic clear_masters();
        m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
        m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
        m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 0;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b1;
        clear_masters();
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_outputs_zero"}, 32'(any_out()), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_read(input bit mst, input logic [31:0] addr, input bit exp_err,
                           input logic exp_sel, input string tag);
        int first_s = -1, hs_cnt = 0;
        bit fin = 0, other_nz = 0, sel_bad = 0, busy_seen = 0, ar_now;
        rsp_t e;
        @(posedge clk); #1;
        if (mst) begin m1_araddr = addr; m1_arvalid = 1; m1_rready = 1; end
        else     begin m0_araddr = addr; m0_arvalid = 1; m0_rready = 1; end
        e.data = exp_err ? 32'h0 : slv_data(addr);
        e.resp = exp_err;
        sb_push(mst, e);
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            @(negedge clk);
            if (s_arvalid && first_s < 0) first_s = cyc;
            if (s_busy) begin busy_seen = 1; if (s_sel !== exp_sel) sel_bad = 1; end
            other_nz |= mst ? m0_any() : m1_any();
            ar_now = mst ? (m1_arvalid && m1_arready) : (m0_arvalid && m0_arready);
            if (ar_now) hs_cnt++;
            if (mst ? m1_rvalid : m0_rvalid) begin
                sb_pop_check(mst, 0, mst ? m1_rdata : m0_rdata, mst ? m1_rresp : m0_rresp, tag);
                fin = 1;
            end
            @(posedge clk); #1;
            if (ar_now) begin if (mst) m1_arvalid = 0; else m0_arvalid = 0; end
            if (fin) begin m0_rready = 0; m1_rready = 0; end
        end
        if (!fin) begin
            fail({tag, "_read_timeout"});
            clear_masters();
        end
        check({tag, "_ar_handshakes"}, 32'(hs_cnt), 32'd1);
        check({tag, "_other_master_quiet"}, 32'(other_nz), 32'h0);
        if (exp_err) begin
            check({tag, "_no_s_arvalid"}, 32'(first_s), 32'hFFFF_FFFF);
            check({tag, "_not_busy"}, 32'(busy_seen), 32'h0);
        end else begin
            check({tag, "_grant_latency"}, 32'(first_s), 32'd1);
            check({tag, "_sel"}, 32'(sel_bad), 32'h0);
            check({tag, "_busy"}, 32'(busy_seen), 32'h1);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                            input int w_delay, input int b_stall, input bit exp_err,
                            input logic exp_sel, input string tag);
        int first_s = -1, aw_cnt = 0, w_cnt = 0, stalls = 0;
        bit fin = 0, other_nz = 0, sel_bad = 0, busy_seen = 0, stall_bad = 0, aw_now, w_now, w_sent;
        rsp_t e;
        @(posedge clk); #1;
        m1_awaddr = addr; m1_awvalid = 1; m1_wdata = wdata; m1_wstrb = strb;
        w_sent = (w_delay == 0);
        m1_wvalid = w_sent;
        m1_bready = (b_stall == 0);
        e.data = 32'h0;
        e.resp = exp_err;
        sb_push(1, e);
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            @(negedge clk);
            if (s_awvalid && first_s < 0) first_s = cyc;
            if (s_busy) begin busy_seen = 1; if (s_sel !== exp_sel) sel_bad = 1; end
            other_nz |= m0_any();
            aw_now = m1_awvalid && m1_awready;
            w_now  = m1_wvalid && m1_wready;
            if (aw_now) aw_cnt++;
            if (w_now)  w_cnt++;
            if (m1_bvalid) begin
                if (m1_bready) begin
                    sb_pop_check(1, 1, 32'h0, m1_bresp, tag);
                    fin = 1;
                end else begin
                    stalls++;
                    if (s_busy !== !exp_err) stall_bad = 1;
                end
            end
            @(posedge clk); #1;
            if (aw_now) m1_awvalid = 0;
            if (w_now)  m1_wvalid = 0;
            if (!w_sent && cyc + 1 >= w_delay) begin m1_wvalid = 1; w_sent = 1; end
            if (stalls >= b_stall) m1_bready = 1;
            if (fin) m1_bready = 0;
        end
        if (!fin) begin
            fail({tag, "_write_timeout"});
            clear_masters();
        end
        check({tag, "_aw_handshakes"}, 32'(aw_cnt), 32'd1);
        check({tag, "_w_handshakes"}, 32'(w_cnt), 32'd1);
        check({tag, "_b_stall_cycles"}, 32'(stalls), 32'(b_stall));
        check({tag, "_stall_state"}, 32'(stall_bad), 32'h0);
        check({tag, "_m0_quiet"}, 32'(other_nz), 32'h0);
        if (exp_err) begin
            check({tag, "_no_s_awvalid"}, 32'(first_s), 32'hFFFF_FFFF);
            check({tag, "_not_busy"}, 32'(busy_seen), 32'h0);
        end else begin
            check({tag, "_grant_latency"}, 32'(first_s), 32'd1);
            check({tag, "_sel"}, 32'(sel_bad), 32'h0);
            check({tag, "_busy"}, 32'(busy_seen), 32'h1);
            check({tag, "_s_awaddr"}, cap_awaddr, addr);
            check({tag, "_s_wdata"}, cap_wdata, wdata);
            check({tag, "_s_wstrb"}, 32'(cap_wstrb), 32'(strb));
        end
    endtask

    // Both masters request continuously; responses must alternate starting with m0.
    task automatic rr_test();
        localparam logic [31:0] A0 = 32'h8000_0100;
        localparam logic [31:0] A1 = 32'h1000_0200;
        int order[$];
        int issued[2];
        bit ar0, ar1, r0, r1;
        rsp_t e0, e1;
        e0.data = slv_data(A0); e0.resp = 1'b0;
        e1.data = slv_data(A1); e1.resp = 1'b0;
        @(posedge clk); #1;
        m0_araddr = A0; m1_araddr = A1;
        m0_arvalid = 1; m1_arvalid = 1; m0_rready = 1; m1_rready = 1;
        sb_push(0, e0); sb_push(1, e1);
        issued[0] = 1; issued[1] = 1;
        for (int cyc = 0; cyc < 300 && order.size() < 6; cyc++) begin
            @(negedge clk);
            ar0 = m0_arvalid && m0_arready;
            ar1 = m1_arvalid && m1_arready;
            r0  = m0_rvalid && m0_rready;
            r1  = m1_rvalid && m1_rready;
            if (r0) begin sb_pop_check(0, 0, m0_rdata, m0_rresp, "rr_m0"); order.push_back(0); end
            if (r1) begin sb_pop_check(1, 0, m1_rdata, m1_rresp, "rr_m1"); order.push_back(1); end
            @(posedge clk); #1;
            if (ar0) m0_arvalid = 0;
            if (ar1) m1_arvalid = 0;
            if (r0 && issued[0] < 3) begin m0_arvalid = 1; sb_push(0, e0); issued[0]++; end
            if (r1 && issued[1] < 3) begin m1_arvalid = 1; sb_push(1, e1); issued[1]++; end
        end
        clear_masters();
        if (order.size() != 6) fail("rr_six_transactions");
        else for (int i = 0; i < 6; i++) check($sformatf("rr_grant%0d", i), 32'(order[i]), 32'(i % 2));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit seen;
        vecs[0] = '{0, 0, 32'h8000_0010, 0, 1'b0};
        vecs[1] = '{0, 1, 32'h80FF_FFFC, 0, 1'b0};
        vecs[2] = '{0, 0, 32'h1000_0FFC, 0, 1'b1};
        vecs[3] = '{0, 1, 32'h1000_1000, 1, 1'b0};
        vecs[4] = '{0, 0, 32'h7FFF_FFFC, 1, 1'b0};
        vecs[5] = '{1, 1, 32'h8100_0000, 1, 1'b0};
        vecs[6] = '{1, 1, 32'h8000_0004, 0, 1'b0};
        vecs[7] = '{1, 1, 32'h1000_0004, 0, 1'b1};
        vecs[8] = '{0, 1, 32'h0000_1000, 1, 1'b0};
        vecs[9] = '{1, 1, 32'h2000_0000, 1, 1'b0};

        rst = 1'b1;
        clear_masters();
        do_reset("reset");

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, ~vecs[i].addr, 4'(i + 1), 0, 0, vecs[i].err, vecs[i].sel,
                         $sformatf("vec%0d", i));
            else
                do_read(vecs[i].mst, vecs[i].addr, vecs[i].err, vecs[i].sel, $sformatf("vec%0d", i));
        end

        do_write(32'h1000_0000, 32'h41, 4'h1, 0, 2, 0, 1'b1, "uart_wr_bstall");
        do_write(32'h2000_0000, 32'h55, 4'hF, 2, 0, 1, 1'b0, "err_wr_late_w");

        do_reset("rr_reset");
        rr_test();

        // Reset while a read response is pending on the downstream port.
        @(posedge clk); #1;
        m0_araddr = 32'h8000_0040; m0_arvalid = 1; m0_rready = 0;
        seen = 0;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            if (m0_rvalid) seen = 1;
            if (m0_arvalid && m0_arready) begin @(posedge clk); #1; m0_arvalid = 0; end
            else if (!seen) begin @(posedge clk); #1; end
        end
        if (!seen) fail("midread_rvalid_pending");
        do_reset("midread_reset");
        do_read(0, 32'h8000_0010, 0, 1'b0, "after_reset_read");

        check("sb0_drained", 32'(sb0.size()), 32'h0);
        check("sb1_drained", 32'(sb1.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
